hex_display_ctrl: RTL and testbench

Sequencing controller that shares a single `hex_to_7seg` decoder instance across NUM_DIGITS static 7-segment displays. It accepts a packed hex word over a valid/ready handshake, then walks the digits MSB-first, one per clock, writing each decoded pattern into a per-digit segment register. Optional leading-zero blanking and a blink overlay are included. It sits between the lab's value source (switches, counter or CPU register) and the board's HEX pins.

---
 rtl/hex_display_ctrl.sv | 142 ++++++++++++++
 tb/tb_hex_display_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// +----------------------------------------------------------------------------+
// | hex_display_ctrl: handshaked hex word -> NUM_DIGITS 7-seg displays        |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] hex_out
);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW   = $clog2(BLINK_DIV);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_lz;
  logic [IDXW-1:0]         r_idx;
  logic                    r_done;
  logic [6:0]              r_seg [NUM_DIGITS];
  logic [CW-1:0]           r_cnt;
  logic                    r_phase_off;

  logic [3:0]              w_nibs [NUM_DIGITS];
  logic [3:0]              w_nib;
  logic [6:0]              w_dec;
  logic                    w_blank;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
    assign w_nibs[i] = r_shadow[4*i +: 4];
  end

  assign w_nib = w_nibs[r_idx];

  hex_to_7seg u_dec (
    .nibble (w_nib),
    .seg    (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_lz     <= 1'b0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_seg[i] <= 7'b1111111;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shadow <= in_data;
            r_lz     <= blank_lz;
            r_idx    <= IDXW'(NUM_DIGITS - 1);
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Digit 0 is never blanked so an all-zero word still reads "0".
          if (r_lz && (w_nib == 4'h0) && (r_idx != '0)) begin
            r_seg[r_idx] <= 7'b1111111;
          end else begin
            r_seg[r_idx] <= w_dec;
            r_lz         <= 1'b0;
          end
          if (r_idx == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_phase_off <= 1'b0;
    end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
      r_cnt       <= '0;
      r_phase_off <= ~r_phase_off;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign done     = r_done;
  assign w_blank  = blink_en && r_phase_off;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_out
    assign hex_out[7*i +: 7] = w_blank ? 7'b1111111 : r_seg[i];
  end
endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_hex_display_ctrl: directed vectors against hand-computed patterns      |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hex_display_ctrl;
  localparam int ND = 6;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4*ND-1:0] in_data;
  logic          blank_lz;
  logic          blink_en;
  logic          done;
  logic [7*ND-1:0] hex_out;

  int n_vec  = 0;
  int n_miss = 0;
  int tb_n;

  localparam logic [41:0] ALL_ON = {42{1'b1}};
  localparam logic [41:0] W_123456 = {7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010};
  localparam logic [41:0] W_00A0F0 = {7'b1111111, 7'b1111111, 7'b0001000,
                                      7'b1000000, 7'b0001110, 7'b1000000};
  localparam logic [41:0] W_000000 = {7'b1111111, 7'b1111111, 7'b1111111,
                                      7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [41:0] W_ABCDEF = {7'b0001000, 7'b0000011, 7'b1000110,
                                      7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [41:0] W_789012 = {7'b1111000, 7'b0000000, 7'b0010000,
                                      7'b1000000, 7'b1111001, 7'b0100100};

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .done     (done),
    .hex_out  (hex_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release; blink phase is OFF when (tb_n / BD) is odd.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_n <= 0;
    else        tb_n <= tb_n + 1;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [23:0] word, input logic lz,
                          input logic [41:0] exp, input logic chk_d5);
    in_data  = word;
    blank_lz = lz;
    in_valid = 1'b1;
    check("ready_at_offer", 48'(in_ready), 48'd1);
    for (int k = 1; k <= ND; k++) begin
      tick();
      in_valid = 1'b0;
      in_data  = 24'hFFFFFF;
      check("ready_in_scan", 48'(in_ready), 48'd0);
      check("done_in_scan", 48'(done), 48'd0);
      if (chk_d5 && k == 1) check("digit5_T+1", 48'(hex_out[41:35]), 48'(7'b1111111));
      if (chk_d5 && k == 2) check("digit5_T+2", 48'(hex_out[41:35]), 48'(7'b1111001));
    end
    tick();
    check("done_pulse", 48'(done), 48'd1);
    check("ready_after", 48'(in_ready), 48'd1);
    check("word_shown", 48'(hex_out), 48'(exp));
    tick();
    check("done_single", 48'(done), 48'd0);
  endtask

  initial begin
    logic found;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    check("rst_hex", 48'(hex_out), 48'(ALL_ON));
    check("rst_ready", 48'(in_ready), 48'd1);
    check("rst_done", 48'(done), 48'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    check("idle_hex", 48'(hex_out), 48'(ALL_ON));

    run_word(24'h123456, 1'b0, W_123456, 1'b1);
    run_word(24'h00A0F0, 1'b1, W_00A0F0, 1'b0);
    run_word(24'h000000, 1'b1, W_000000, 1'b0);

    // Held in_valid with churning data: only words at accept cycles land.
    blank_lz = 1'b0;
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k <= ND; k++) begin
        tick();
        in_data = 24'h333333 + 24'(k);
        check("hold_done_low", 48'(done), 48'd0);
      end
      tick();
      check("hold_done", 48'(done), 48'd1);
      check("hold_word", 48'(hex_out), (w == 0) ? 48'(W_ABCDEF) : 48'(W_789012));
      in_data = 24'h789012;
      if (w == 1) in_valid = 1'b0;
    end

    blink_en = 1'b1;
    #1;
    check("blink_now", 48'(hex_out), ((tb_n / BD) % 2 == 1) ? 48'(ALL_ON) : 48'(W_789012));
    for (int k = 0; k < 12; k++) begin
      tick();
      check("blink_cyc", 48'(hex_out), ((tb_n / BD) % 2 == 1) ? 48'(ALL_ON) : 48'(W_789012));
    end
    found = 1'b0;
    for (int k = 0; k < 2 * BD && !found; k++) begin
      if ((tb_n / BD) % 2 == 1) found = 1'b1;
      else tick();
    end
    check("blink_off_found", 48'(found), 48'd1);
    check("blink_off_dark", 48'(hex_out), 48'(ALL_ON));
    blink_en = 1'b0;
    #1;
    check("blink_release", 48'(hex_out), 48'(W_789012));

    // Async reset three cycles into a scan discards the partial word.
    tick();
    in_data  = 24'h456789;
    in_valid = 1'b1;
    check("ready_pre_rst", 48'(in_ready), 48'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      in_valid = 1'b0;
    end
    check("partial_d5", 48'(hex_out[41:35]), 48'(7'b0011001));
    rst_n = 1'b0;
    #1;
    check("midrst_hex", 48'(hex_out), 48'(ALL_ON));
    check("midrst_ready", 48'(in_ready), 48'd1);
    check("midrst_done", 48'(done), 48'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_done", 48'(done), 48'd0);
      check("post_rst_hex", 48'(hex_out), 48'(ALL_ON));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

`default_nettype wire
